sprite_draw_engine: RTL and testbench
=====================================

// Module: sprite_draw_engine
// PURPOSE
//  Parametrised rectangle/sprite plotter on the shared datapath-instruction port.
//  Reads an object's X/Y position from memory (two MEMREAD transactions) and issues one DRAW per pixel of a SPRITE_W x SPRITE_H block.
//  Adds erase mode (background colour), screen-edge clipping and a configurable origin offset.
//  Serves ants, food and future sprite types.
// PARAMETERS
//  SPRITE_W   2    sprite width in pixels (1..2^X_W-1)
//  SPRITE_H   2    sprite height in pixels (1..2^Y_W-1)
//  SCREEN_W   160  visible width; pixels with x >= SCREEN_W are clipped
//  SCREEN_H   120  visible height; pixels with y >= SCREEN_H are clipped
//  ORIGIN_OFF 1    subtracted from the loaded X and Y to form the top-left corner
// PORTS
//  clock        in   1                 system clock
//  resetn       in   1                 sync, active-low reset
//  start        in   1                 request; sampled only in IDLE
//  finished     out  1                 high in IDLE; low while busy
//  erase        in   1                 latched at start; 1 = draw with colour_bg
//  colour_fg    in   `COLOUR_WIDTH     latched at start; colour for draw mode
//  colour_bg    in   `COLOUR_WIDTH     latched at start; colour for erase mode
//  addr_x       in   `MEM_ADDR_WIDTH   latched at start; memory address of X
//  addr_y       in   `MEM_ADDR_WIDTH   latched at start; memory address of Y
//  drawn_count  out  16                DRAWs issued by the last/current job
//  finished_dp  in   1                 datapath transaction complete
//  result_dp    in   `RESULT_WIDTH     datapath read data
//  start_dp     out  1                 datapath request
//  instruction_dp out `INSTRUCTION_WIDTH datapath instruction
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state IDLE; finished=1, start_dp=0, instruction_dp=0, drawn_count=0.
//   All internal registers clear. Reset mid-job aborts immediately; no further DRAW is issued.
//  Transaction rule, applied to every datapath access:
//   - ISSUE cycle: drive instruction_dp, start_dp=1.
//   - HOLD cycle: start_dp=1, instruction unchanged.
//   - WAIT: start_dp=0 until finished_dp=1 is sampled.
//   - finished_dp is ignored outside WAIT; instruction_dp holds until the next ISSUE.
//  States and transitions:
//   - IDLE: on start latch inputs, clear drawn_count, dx=dy=0, finished=0 -> RDX.
//   - RDX (ISSUE/HOLD/WAIT): instruction {addr_x, `OPCODE_MEMREAD}.
//     On finished_dp: x0 = result_dp[`X_COORD_WIDTH-1:0] - ORIGIN_OFF (mod 2^X_W) -> RDY.
//   - RDY: same sequence with addr_y; y0 = result_dp - ORIGIN_OFF (mod 2^Y_W) -> PIX.
//   - PIX (1 cycle): px=x0+dx, py=y0+dy, computed one bit wider than the coordinate (no wrap).
//     If px<SCREEN_W && py<SCREEN_H -> DRAW, else skip -> STEP.
//   - DRAW (ISSUE/HOLD/WAIT): instruction {1'b1, col, py, px, `OPCODE_DRAW},
//     col = erase ? colour_bg : colour_fg. On finished_dp: drawn_count+1 -> STEP.
//   - STEP (1 cycle): raster order, dx first.
//     dx==SPRITE_W-1: dx=0; then if dy==SPRITE_H-1 -> IDLE (finished=1 same edge), else dy+1 -> PIX.
//     Otherwise dx+1 -> PIX.
//  Clipping: a loaded position of 0 with ORIGIN_OFF=1 gives x0=all-ones, so every column is clipped.
//   A fully clipped sprite issues zero DRAWs and still completes.
//  start while busy is ignored. start coincident with reset: reset wins.
//  Latency for an unclipped job with datapath finish delay D (cycles after HOLD):
//   (2+D)*(2+N) + 2N + 1 cycles, N = SPRITE_W*SPRITE_H.
// STRUCTURE
//  Shared header constants.h holds: `OPCODE_*, `COLOUR_WIDTH, `X/Y_COORD_WIDTH, `MEM_ADDR_WIDTH,
//   `RESULT_WIDTH, `INSTRUCTION_WIDTH, `SCREEN_WIDTH/HEIGHT.
//  Add `SDE_ST_* state encodings (4-bit) to constants.h.
//  Sub-module dp_txn (ISSUE/HOLD/WAIT sequencer):
//   inputs go, instr, finished_dp; outputs start_dp, instruction_dp, done.
//   Reused by every access; the top FSM only selects the instruction.
// TESTING
//  - Model datapath responds D=3; mem[ax]=11, mem[ay]=21; erase=0, colour_fg=3'b100:
//    exactly 4 DRAWs at (10,20),(11,20),(10,21),(11,21) in that order, colour 100; drawn_count=4; finished rises.
//  - Same with erase=1, colour_bg=3'b000: same 4 coordinates with colour 000.
//  - mem[ax]=160 (x0=159): only column 159 drawn, 2 DRAWs; drawn_count=2.
//  - mem[ax]=0: 0 DRAWs; finished returns high after the two reads.
//  - Datapath holds finished_dp=1 permanently: each access still shows start_dp high for exactly 2 cycles.
//    Pulse start during busy: no second job starts.
//  - Assert resetn=0 during the 2nd DRAW WAIT: next cycle start_dp=0, finished=1, drawn_count=0;
//    a new start runs a full 4-pixel job.

Source files
------------

// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants, state encodings and instruction builders for the sprite draw engine.
package sprite_draw_engine_pkg;

  localparam int COLOUR_WIDTH      = 3;
  localparam int X_COORD_WIDTH     = 8;
  localparam int Y_COORD_WIDTH     = 7;
  localparam int MEM_ADDR_WIDTH    = 12;
  localparam int RESULT_WIDTH      = 16;
  localparam int OPCODE_WIDTH      = 3;
  localparam int INSTRUCTION_WIDTH = 1 + COLOUR_WIDTH + Y_COORD_WIDTH + X_COORD_WIDTH + OPCODE_WIDTH;
  localparam int SCREEN_WIDTH      = 160;
  localparam int SCREEN_HEIGHT     = 120;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOP     = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_MEMREAD = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW    = 3'd2;

  typedef enum logic [3:0] {
    SDE_ST_IDLE = 4'd0,
    SDE_ST_RDX  = 4'd1,
    SDE_ST_RDY  = 4'd2,
    SDE_ST_PIX  = 4'd3,
    SDE_ST_DRAW = 4'd4,
    SDE_ST_STEP = 4'd5
  } sde_state_t;

  typedef enum logic [1:0] {
    TXN_IDLE  = 2'd0,
    TXN_ISSUE = 2'd1,
    TXN_HOLD  = 2'd2,
    TXN_WAIT  = 2'd3
  } txn_phase_t;

  // Memory reads put the address directly above the opcode; upper bits stay zero.
  function automatic logic [INSTRUCTION_WIDTH-1:0] memread_instr(
    input logic [MEM_ADDR_WIDTH-1:0] addr
  );
    memread_instr = '0;
    memread_instr[MEM_ADDR_WIDTH+OPCODE_WIDTH-1:0] = {addr, OPCODE_MEMREAD};
  endfunction

  function automatic logic [INSTRUCTION_WIDTH-1:0] draw_instr(
    input logic [COLOUR_WIDTH-1:0]  col,
    input logic [Y_COORD_WIDTH-1:0] py,
    input logic [X_COORD_WIDTH-1:0] px
  );
    draw_instr = {1'b1, col, py, px, OPCODE_DRAW};
  endfunction

endpackage

// File: rtl/sprite_draw_engine_dp_txn.sv
// ISSUE/HOLD/WAIT sequencer shared by every datapath access of the sprite engine.
// Handshake: go (one cycle) loads instr; start_dp is high for exactly ISSUE and HOLD,
// then done pulses in the WAIT cycle where finished_dp is seen. finished_dp is ignored elsewhere.
module sprite_draw_engine_dp_txn
  import sprite_draw_engine_pkg::*;
(
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         go,
  input  logic [INSTRUCTION_WIDTH-1:0] instr,
  input  logic                         finished_dp,
  output logic                         start_dp,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
  output logic                         done
);

  txn_phase_t phase, phase_next;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase          <= TXN_IDLE;
      instruction_dp <= '0;
    end else begin
      phase <= phase_next;
      if (go) instruction_dp <= instr;
    end
  end

  always_comb begin
    phase_next = phase;
    if (go) begin
      phase_next = TXN_ISSUE;
    end else begin
      case (phase)
        TXN_ISSUE: phase_next = TXN_HOLD;
        TXN_HOLD:  phase_next = TXN_WAIT;
        TXN_WAIT:  if (finished_dp) phase_next = TXN_IDLE;
        default:   phase_next = TXN_IDLE;
      endcase
    end
  end

  assign start_dp = (phase == TXN_ISSUE) || (phase == TXN_HOLD);
  assign done     = (phase == TXN_WAIT) && finished_dp;

endmodule

// File: rtl/sprite_draw_engine.sv
// Reads an object's X/Y from memory and plots a clipped SPRITE_W x SPRITE_H block,
// one DRAW per visible pixel in raster order, in foreground or background colour.
module sprite_draw_engine
  import sprite_draw_engine_pkg::*;
#(
  parameter int SPRITE_W   = 2,
  parameter int SPRITE_H   = 2,
  parameter int SCREEN_W   = SCREEN_WIDTH,
  parameter int SCREEN_H   = SCREEN_HEIGHT,
  parameter int ORIGIN_OFF = 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  output logic                         finished,
  input  logic                         erase,
  input  logic [COLOUR_WIDTH-1:0]      colour_fg,
  input  logic [COLOUR_WIDTH-1:0]      colour_bg,
  input  logic [MEM_ADDR_WIDTH-1:0]    addr_x,
  input  logic [MEM_ADDR_WIDTH-1:0]    addr_y,
  output logic [15:0]                  drawn_count,
  input  logic                         finished_dp,
  input  logic [RESULT_WIDTH-1:0]      result_dp,
  output logic                         start_dp,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

  sde_state_t state, state_next;

  logic [COLOUR_WIDTH-1:0]      col_q;
  logic [MEM_ADDR_WIDTH-1:0]    addr_y_q;
  logic [X_COORD_WIDTH-1:0]     x0, dx;
  logic [Y_COORD_WIDTH-1:0]     y0, dy;
  logic [X_COORD_WIDTH:0]       px;
  logic [Y_COORD_WIDTH:0]       py;
  logic                         visible, last_col, last_row;
  logic                         go, done;
  logic [INSTRUCTION_WIDTH-1:0] instr;
  logic                         unused_result;

  // One bit wider than the coordinate so an offset past the edge clips instead of wrapping.
  assign px       = {1'b0, x0} + {1'b0, dx};
  assign py       = {1'b0, y0} + {1'b0, dy};
  assign visible  = (px < (X_COORD_WIDTH+1)'(SCREEN_W)) && (py < (Y_COORD_WIDTH+1)'(SCREEN_H));
  assign last_col = (dx == X_COORD_WIDTH'(SPRITE_W - 1));
  assign last_row = (dy == Y_COORD_WIDTH'(SPRITE_H - 1));
  assign finished = (state == SDE_ST_IDLE);
  assign unused_result = ^result_dp[RESULT_WIDTH-1:X_COORD_WIDTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= SDE_ST_IDLE;
      col_q       <= '0;
      addr_y_q    <= '0;
      x0          <= '0;
      y0          <= '0;
      dx          <= '0;
      dy          <= '0;
      drawn_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        SDE_ST_IDLE: if (start) begin
          col_q       <= erase ? colour_bg : colour_fg;
          addr_y_q    <= addr_y;
          dx          <= '0;
          dy          <= '0;
          drawn_count <= '0;
        end
        SDE_ST_RDX: if (done) x0 <= result_dp[X_COORD_WIDTH-1:0] - X_COORD_WIDTH'(ORIGIN_OFF);
        SDE_ST_RDY: if (done) y0 <= result_dp[Y_COORD_WIDTH-1:0] - Y_COORD_WIDTH'(ORIGIN_OFF);
        SDE_ST_DRAW: if (done) drawn_count <= drawn_count + 16'd1;
        SDE_ST_STEP: begin
          if (last_col) begin
            dx <= '0;
            if (!last_row) dy <= dy + 1'b1;
          end else begin
            dx <= dx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    instr      = '0;
    case (state)
      SDE_ST_IDLE: if (start) begin
        go         = 1'b1;
        instr      = memread_instr(addr_x);
        state_next = SDE_ST_RDX;
      end
      SDE_ST_RDX: if (done) begin
        go         = 1'b1;
        instr      = memread_instr(addr_y_q);
        state_next = SDE_ST_RDY;
      end
      SDE_ST_RDY: if (done) state_next = SDE_ST_PIX;
      SDE_ST_PIX: begin
        if (visible) begin
          go         = 1'b1;
          instr      = draw_instr(col_q, py[Y_COORD_WIDTH-1:0], px[X_COORD_WIDTH-1:0]);
          state_next = SDE_ST_DRAW;
        end else begin
          state_next = SDE_ST_STEP;
        end
      end
      SDE_ST_DRAW: if (done) state_next = SDE_ST_STEP;
      SDE_ST_STEP: state_next = (last_col && last_row) ? SDE_ST_IDLE : SDE_ST_PIX;
      default: state_next = SDE_ST_IDLE;
    endcase
  end

  sprite_draw_engine_dp_txn u_txn (
    .clock          (clock),
    .resetn         (resetn),
    .go             (go),
    .instr          (instr),
    .finished_dp    (finished_dp),
    .start_dp       (start_dp),
    .instruction_dp (instruction_dp),
    .done           (done)
  );

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Bench for sprite_draw_engine: datapath/memory model, DRAW scoreboard and scenario tasks.
module tb_sprite_draw_engine;
  import sprite_draw_engine_pkg::*;

  localparam int IW = INSTRUCTION_WIDTH;
  localparam logic [MEM_ADDR_WIDTH-1:0] AX = 12'h010;
  localparam logic [MEM_ADDR_WIDTH-1:0] AY = 12'h011;

  logic                      clock = 1'b0;
  logic                      resetn = 1'b0;
  logic                      start = 1'b0;
  logic                      erase = 1'b0;
  logic [COLOUR_WIDTH-1:0]   colour_fg = 3'b100;
  logic [COLOUR_WIDTH-1:0]   colour_bg = 3'b000;
  logic [MEM_ADDR_WIDTH-1:0] addr_x = AX;
  logic [MEM_ADDR_WIDTH-1:0] addr_y = AY;
  logic                      finished;
  logic [15:0]               drawn_count;
  logic                      finished_dp;
  logic [RESULT_WIDTH-1:0]   result_dp;
  logic                      start_dp;
  logic [IW-1:0]             instruction_dp;

  sprite_draw_engine dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .finished       (finished),
    .erase          (erase),
    .colour_fg      (colour_fg),
    .colour_bg      (colour_bg),
    .addr_x         (addr_x),
    .addr_y         (addr_y),
    .drawn_count    (drawn_count),
    .finished_dp    (finished_dp),
    .result_dp      (result_dp),
    .start_dp       (start_dp),
    .instruction_dp (instruction_dp)
  );

  // Clock
  always #5 clock = ~clock;

  // Datapath model: finished_dp on the d_delay-th WAIT cycle, or always high in perm mode.
  int                      d_delay = 3;
  bit                      perm_finish = 1'b0;
  logic                    pending = 1'b0;
  int                      wcnt = 0;
  logic [RESULT_WIDTH-1:0] mem_x = 16'd11;
  logic [RESULT_WIDTH-1:0] mem_y = 16'd21;

  always @(posedge clock) begin
    if (!resetn) begin
      pending <= 1'b0;
      wcnt    <= 0;
    end else if (start_dp) begin
      pending <= 1'b1;
      wcnt    <= 0;
    end else if (pending) begin
      if (finished_dp) pending <= 1'b0;
      else             wcnt    <= wcnt + 1;
    end
  end

  assign finished_dp = perm_finish | (pending & ~start_dp & (wcnt == d_delay - 1));
  assign result_dp   = (instruction_dp[MEM_ADDR_WIDTH+OPCODE_WIDTH-1:OPCODE_WIDTH] == AX) ? mem_x : mem_y;

  // Scoreboard and counters
  logic [IW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            draws_seen = 0;
  logic          prev_start = 1'b0;
  int            run_len = 0;
  logic [IW-1:0] issue_instr;

  // Monitor: every start_dp burst must be 2 cycles with a stable instruction; DRAWs pop the queue.
  always @(negedge clock) begin
    logic [IW-1:0] exp;
    if (start_dp === 1'b1) begin
      if (prev_start !== 1'b1) begin
        issue_instr = instruction_dp;
        run_len     = 1;
        if (instruction_dp[OPCODE_WIDTH-1:0] == OPCODE_DRAW) begin
          draws_seen++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL draw_unexpected: got %h, required no DRAW", instruction_dp);
          end else begin
            exp = exp_q.pop_front();
            if (instruction_dp !== exp) begin
              n_fail++;
              $display("FAIL draw_instr: got %h, required %h", instruction_dp, exp);
            end
          end
        end
      end else begin
        run_len++;
        n_checks++;
        if (instruction_dp !== issue_instr) begin
          n_fail++;
          $display("FAIL instr_hold: got %h, required %h", instruction_dp, issue_instr);
        end
      end
    end else if (prev_start === 1'b1) begin
      n_checks++;
      if (run_len != 2) begin
        n_fail++;
        $display("FAIL start_len: got %0d cycles, required 2", run_len);
      end
    end
    prev_start = start_dp;
  end

  // Reference model of the sprite: raster order, clip at 160x120, origin offset 1.
  task automatic push_expected(input bit erase_v, output int cnt);
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] col;
    int         px, py;
    logic [7:0] pxv;
    logic [6:0] pyv;
    x0  = mem_x[7:0] - 8'd1;
    y0  = mem_y[6:0] - 7'd1;
    col = erase_v ? colour_bg : colour_fg;
    cnt = 0;
    for (int ry = 0; ry < 2; ry++) begin
      for (int rx = 0; rx < 2; rx++) begin
        px = int'(x0) + rx;
        py = int'(y0) + ry;
        if (px < 160 && py < 120) begin
          pxv = px[7:0];
          pyv = py[6:0];
          exp_q.push_back({1'b1, col, pyv, pxv, 3'd2});
          cnt++;
        end
      end
    end
  endtask

  task automatic run_job(input bit erase_v, input logic [15:0] mx, input logic [15:0] my,
                         input bit check_lat, input int exp_lat, input bit busy_pulse);
    int  exp_cnt;
    int  cyc;
    bit  done;
    erase = erase_v;
    mem_x = mx;
    mem_y = my;
    push_expected(erase_v, exp_cnt);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n_checks++;
    if (finished !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_flag: finished=%b, required 0", finished);
    end
    cyc  = 1;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clock);
      #1 cyc++;
      start = busy_pulse && (cyc == 10);
      if (finished === 1'b1) done = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL job_timeout: finished=%b after %0d cycles, required 1", finished, cyc);
    end
    if (check_lat) begin
      n_checks++;
      if (cyc != exp_lat) begin
        n_fail++;
        $display("FAIL latency: got %0d cycles, required %0d", cyc, exp_lat);
      end
    end
    n_checks++;
    if (drawn_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL drawn_count: got %0d, required %0d", drawn_count, exp_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL draws_missing: %0d DRAWs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (finished !== 1'b1) begin n_fail++; $display("FAIL reset_finished: got %b, required 1", finished); end
    n_checks++;
    if (start_dp !== 1'b0) begin n_fail++; $display("FAIL reset_start_dp: got %b, required 0", start_dp); end
    n_checks++;
    if (instruction_dp !== '0) begin n_fail++; $display("FAIL reset_instr: got %h, required 0", instruction_dp); end
    n_checks++;
    if (drawn_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", drawn_count); end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_draw();
    d_delay = 3;
    colour_fg = 3'b100;
    run_job(1'b0, 16'd11, 16'd21, 1'b1, 39, 1'b0);
  endtask

  task automatic test_erase();
    colour_bg = 3'b000;
    run_job(1'b1, 16'd11, 16'd21, 1'b1, 39, 1'b0);
  endtask

  task automatic test_clip_edge();
    run_job(1'b0, 16'd160, 16'd21, 1'b0, 0, 1'b0);
  endtask

  task automatic test_clip_all();
    run_job(1'b0, 16'd0, 16'd21, 1'b0, 0, 1'b0);
  endtask

  task automatic test_busy_start();
    bit quiet;
    perm_finish = 1'b1;
    colour_fg   = 3'(($urandom_range(1, 7)));
    run_job(1'b0, 16'($urandom_range(1, 100)), 16'($urandom_range(1, 100)), 1'b1, 27, 1'b1);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (start_dp !== 1'b0 || finished !== 1'b1) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL busy_start_ignored: start_dp/finished active after job, required idle");
    end
    perm_finish = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int  exp_cnt;
    int  target;
    int  seen;
    d_delay = 3;
    erase   = 1'b0;
    mem_x   = 16'd11;
    mem_y   = 16'd21;
    push_expected(1'b0, exp_cnt);
    target = draws_seen + 2;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 0; i < 200 && draws_seen < target; i++) @(posedge clock);
    n_checks++;
    if (draws_seen < target) begin
      n_fail++;
      $display("FAIL second_draw_timeout: saw %0d DRAWs, required %0d", draws_seen, target);
    end
    @(posedge clock);
    #1 resetn = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (start_dp !== 1'b0) begin n_fail++; $display("FAIL abort_start_dp: got %b, required 0", start_dp); end
    n_checks++;
    if (finished !== 1'b1) begin n_fail++; $display("FAIL abort_finished: got %b, required 1", finished); end
    n_checks++;
    if (drawn_count !== 16'd0) begin n_fail++; $display("FAIL abort_count: got %0d, required 0", drawn_count); end
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    seen = draws_seen;
    repeat (20) @(posedge clock);
    n_checks++;
    if (draws_seen != seen) begin
      n_fail++;
      $display("FAIL abort_no_draw: got %0d DRAWs after reset, required 0", draws_seen - seen);
    end
    run_job(1'b0, 16'd11, 16'd21, 1'b1, 39, 1'b0);
  endtask

  initial begin
    test_reset();
    test_draw();
    test_erase();
    test_clip_edge();
    test_clip_all();
    test_busy_start();
    test_reset_mid_job();
    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
